// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline stage register with flush and optional perf counters.
// Define PIPE_STAGE_REG_PERF_EN to build the saturating stall/flush counters.
module pipe_stage_reg #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              main_load_in, main_load_skid, skid_load;
  logic              in_fire, out_fire;

  // in_ready depends only on registered state, so out_ready never reaches it
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Bubbles present all-zero so downstream write enables stay low
  assign out_data  = out_valid ? main_data : '0;
  assign out_ctrl  = out_valid ? main_ctrl : '0;

  always_comb begin
    occupancy = 2'd0;
    case (state)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    state_next     = state;
    main_load_in   = 1'b0;
    main_load_skid = 1'b0;
    skid_load      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          main_load_in = 1'b1;
          state_next   = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_load_in = 1'b1;
        end else if (in_fire) begin
          skid_load  = 1'b1;
          state_next = FULL;
        end else if (out_fire) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_load_skid = 1'b1;
          state_next     = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Reset and flush both wipe the stage; reset additionally clears the counters below
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      state <= state_next;
      if (main_load_in) begin
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else if (main_load_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
      if (skid_load) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end
    end
  end

`ifdef PIPE_STAGE_REG_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
        stall_q <= stall_q + 1'b1;
      if (flush && (flush_q != {CNT_W{1'b1}}))
        flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
